ahb_mbox_mon: RTL and testbench
===============================

AHB_MBOX_MON -- requirements
Module: ahb_mbox_mon

Interface
REQ-001 Parameter DW, default 64, AHB data width in bits; legal values 32 or 64.
REQ-002 Parameter MBOX_ADDR, default 32'hD0580000, mailbox byte address.
REQ-003 Parameter FIFO_DEPTH, default 16, character FIFO entries; power of two, at least 2.
REQ-004 Parameter MAX_CYCLES, default 32'h800, watchdog limit in core_clk cycles.
REQ-005 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-006 core_clk  in  1  block clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 haddr  in  32  snooped AHB address.
REQ-009 htrans  in  2  snooped AHB transfer type.
REQ-010 hwrite  in  1  snooped AHB write flag.
REQ-011 hwdata  in  DW  snooped AHB write data.
REQ-012 hready  in  1  snooped AHB ready.
REQ-013 char_valid  out  1  FIFO head character is valid.
REQ-014 char_data  out  8  FIFO head character.
REQ-015 char_ready  in  1  consumer accepts the head character.
REQ-016 status  out  3  status state encoding.
REQ-017 done  out  1  high in PASS, FAIL or TIMEOUT.
REQ-018 cycle_cnt  out  32  core_clk cycles spent in RUN.
REQ-019 drop_cnt  out  16  characters dropped because the FIFO was full.

Function
REQ-020 Address phase: an access is captured when htrans[1]=1, hwrite=1, hready=1 and haddr equals MBOX_ADDR with the low log2(DW/8) bits cleared.
REQ-021 Data phase: the next cycle with hready=1 takes byte b from hwdata lane MBOX_ADDR[log2(DW/8)-1:0]; one cycle of latency from that cycle to the FIFO or status update.
REQ-022 A new address phase in the same cycle as a pending data phase is captured as well, so back-to-back writes are supported.
REQ-023 Byte 8'h06 < b < 8'h7F pushes b into the FIFO.
REQ-024 Byte 8'hFF drives the state to PASS; byte 8'h01 drives it to FAIL; every other byte is ignored.
REQ-025 FIFO handshake: a pop occurs when char_valid=1 and char_ready=1; char_data is stable while char_valid=1 and char_ready=0.
REQ-026 A push to a full FIFO is dropped and increments drop_cnt, which saturates at 16'hFFFF.
REQ-027 A push and a pop in the same cycle on a full FIFO are both accepted, with no drop.
REQ-028 A push to an empty FIFO makes char_valid=1 on the next cycle.
REQ-029 Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
REQ-030 The state machine has states IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4.
REQ-031 IDLE goes to RUN on the first cycle after rst is deasserted.
REQ-032 RUN goes to PASS, FAIL or TIMEOUT as defined; PASS, FAIL and TIMEOUT are terminal until rst.
REQ-033 In a terminal state, snooped writes are ignored and the FIFO continues to drain.
REQ-034 cycle_cnt increments in RUN only and freezes in terminal states.
REQ-035 If a terminating byte and the watchdog limit occur in the same cycle, the byte wins.

Reset
REQ-036 rst SHALL set: status=IDLE, done=0, char_valid=0, char_data=0, cycle_cnt=0, drop_cnt=0, FIFO empty, pending data phase cleared.
REQ-037 rst asserted mid-transfer discards the pending data phase and all FIFO contents.

Configuration
REQ-038 Macro RV_MBOX_WDOG_EN defined: in RUN, when cycle_cnt reaches MAX_CYCLES the state goes to TIMEOUT on the next cycle.
REQ-039 RV_MBOX_WDOG_EN undefined: the TIMEOUT state is never entered, and cycle_cnt wraps at 2^32.

Structure
REQ-040 Package mbox_pkg holds the status enum typedef and the byte constants CHAR_LO=8'h06, CHAR_HI=8'h7F, BYTE_PASS=8'hFF, BYTE_FAIL=8'h01.
REQ-041 The FIFO is a sub-module mbox_fifo, parametrised by width and depth, with a push/pop/full/empty interface.

Verification
REQ-042 Reset, then write 8'h48 to D0580000 with char_ready=1 -> char_valid=1, char_data=8'h48 one cycle after the data phase; status=RUN.
REQ-043 DW=32, MBOX_ADDR=D0580002, write 32'h00410000 -> char_data=8'h41.
REQ-044 FIFO_DEPTH=4, char_ready=0, 6 printable writes -> 4 entries held, drop_cnt=2; after releasing char_ready, the first 4 characters come out in order.
REQ-045 Write 8'hFF -> status=PASS, done=1, cycle_cnt frozen; a later write of 8'h41 is ignored.
REQ-046 RV_MBOX_WDOG_EN defined, MAX_CYCLES=16, no writes -> status=TIMEOUT on cycle 17 of RUN; with the macro undefined, status stays RUN.
REQ-047 Assert rst while 2 characters are queued and a data phase is pending -> next cycle char_valid=0, status=IDLE, drop_cnt=0.

Source files
------------

// File: rtl/mbox_pkg.sv
// Shared types and byte codes for the AHB mailbox monitor.
package mbox_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } status_e;

    localparam logic [7:0] CHAR_LO   = 8'h06;
    localparam logic [7:0] CHAR_HI   = 8'h7F;
    localparam logic [7:0] BYTE_PASS = 8'hFF;
    localparam logic [7:0] BYTE_FAIL = 8'h01;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    function automatic logic is_printable(input logic [7:0] b);
        return (b > CHAR_LO) && (b < CHAR_HI);
    endfunction

    function automatic logic is_terminal(input status_e s);
        return s inside {ST_PASS, ST_FAIL, ST_TIMEOUT};
    endfunction

endpackage

// File: rtl/ahb_mbox_mon_if.sv
// Snooped AHB write-side signals; the monitor only ever observes them.
interface ahb_mbox_mon_if #(
    parameter int unsigned DW = 64
);
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [DW-1:0] hwdata;
    logic          hready;

    modport master (output haddr, htrans, hwrite, hwdata, hready);
    modport slave  (input  haddr, htrans, hwrite, hwdata, hready);
endinterface

// File: rtl/mbox_fifo.sv
// Power-of-two FIFO with registered head (valid/rdata) and same-cycle push+pop when full.
module mbox_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full_c,
    output logic             valid,
    output logic [WIDTH-1:0] rdata
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             push_ok_c, pop_ok_c;

    always_comb begin
        mem_d     = mem_q;
        rdata_d   = rdata_q;
        full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok_c  = pop && valid_q;
        push_ok_c = push && (!full_c || pop_ok_c);
        wr_ptr_d  = wr_ptr_q + PW'(push_ok_c);
        rd_ptr_d  = rd_ptr_q + PW'(pop_ok_c);
        valid_d   = (wr_ptr_d != rd_ptr_d);
        if (push_ok_c) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
        end
        // New head comes straight from wdata when the FIFO was drained this cycle
        if (valid_d) begin
            rdata_d = (push_ok_c && (wr_ptr_q == rd_ptr_d)) ? wdata : mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            rdata_q  <= rdata_d;
        end
        mem_q <= mem_d;
    end

    assign valid = valid_q;
    assign rdata = rdata_q;

endmodule

// File: rtl/ahb_mbox_mon.sv
// Snoops AHB writes to a mailbox address, queues printable bytes and tracks PASS/FAIL.
// Define RV_MBOX_WDOG_EN to enable the RUN-state watchdog that ends in TIMEOUT.
module ahb_mbox_mon
    import mbox_pkg::*;
#(
    parameter int unsigned DW         = 64,
    parameter logic [31:0] MBOX_ADDR  = 32'hD058_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] MAX_CYCLES = 32'h800
) (
    input  logic                 core_clk,
    input  logic                 rst,
    ahb_mbox_mon_if.slave        ahb,
    output logic                 char_valid,
    output logic [7:0]           char_data,
    input  logic                 char_ready,
    output logic [2:0]           status,
    output logic                 done,
    output logic [31:0]          cycle_cnt,
    output logic [15:0]          drop_cnt
);
    localparam int unsigned LANE_BITS    = $clog2(DW / 8);
    localparam logic [31:0] LANE_MASK    = (32'd1 << LANE_BITS) - 32'd1;
    localparam logic [31:0] ADDR_ALIGNED = MBOX_ADDR & ~LANE_MASK;
    localparam int unsigned LANE_SHIFT   = (MBOX_ADDR & LANE_MASK) << 3;
`ifdef RV_MBOX_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    status_e     state_q, state_d;
    logic        pend_q, pend_d;
    logic        done_q, done_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] drop_q, drop_d;
    logic        addr_hit_c, data_vld_c, push_c, pop_c, drop_c, wdog_hit_c, fifo_full_c;
    logic [7:0]  wbyte_c;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_hit_c = ahb.hready && ahb.hwrite && (ahb.htrans inside {HTRANS_NONSEQ, HTRANS_SEQ})
                     && (ahb.haddr == ADDR_ALIGNED);
        wbyte_c    = 8'(ahb.hwdata >> LANE_SHIFT);
        data_vld_c = pend_q && ahb.hready && !is_terminal(state_q);
        push_c     = data_vld_c && is_printable(wbyte_c);
        pop_c      = char_valid && char_ready;
        drop_c     = push_c && fifo_full_c && !pop_c;
        wdog_hit_c = WDOG_EN && (cnt_q == MAX_CYCLES);
        // A stalled data phase stays pending; a new address phase overlaps the current data phase
        pend_d     = ahb.hready ? addr_hit_c : pend_q;
        drop_d     = (drop_c && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                cnt_d = cnt_q + 32'd1;
                if (data_vld_c && (wbyte_c == BYTE_PASS)) begin
                    state_d = ST_PASS;
                end else if (data_vld_c && (wbyte_c == BYTE_FAIL)) begin
                    state_d = ST_FAIL;
                end else if (wdog_hit_c) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: ;
        endcase
        done_d = is_terminal(state_d);
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    mbox_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (core_clk),
        .rst    (rst),
        .push   (push_c),
        .wdata  (wbyte_c),
        .pop    (char_ready),
        .full_c (fifo_full_c),
        .valid  (char_valid),
        .rdata  (char_data)
    );

    assign status    = state_q;
    assign done      = done_q;
    assign cycle_cnt = cnt_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_ahb_mbox_mon.sv
// Bench for ahb_mbox_mon: directed table, corner sequences and random traffic against a queue model.
module tb_ahb_mbox_mon;

    localparam logic [31:0] ADDR_A  = 32'hD058_0000;
    localparam int unsigned DEPTH_A = 4;
    localparam logic [31:0] MAX_A   = 32'h800;
    localparam logic [31:0] ADDR_B  = 32'hD058_0002;
    localparam logic [31:0] MAX_B   = 32'd16;
`ifdef RV_MBOX_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ready_a, ready_b;
    logic        a_valid, b_valid, a_done, b_done;
    logic [7:0]  a_data, b_data;
    logic [2:0]  a_status, b_status;
    logic [31:0] a_cnt, b_cnt;
    logic [15:0] a_drop, b_drop;

    ahb_mbox_mon_if #(.DW(64)) bus_a ();
    ahb_mbox_mon_if #(.DW(32)) bus_b ();

    ahb_mbox_mon #(.DW(64), .MBOX_ADDR(ADDR_A), .FIFO_DEPTH(DEPTH_A), .MAX_CYCLES(MAX_A)) dut_a (
        .core_clk(clk), .rst(rst), .ahb(bus_a), .char_valid(a_valid), .char_data(a_data),
        .char_ready(ready_a), .status(a_status), .done(a_done), .cycle_cnt(a_cnt), .drop_cnt(a_drop));

    ahb_mbox_mon #(.DW(32), .MBOX_ADDR(ADDR_B), .FIFO_DEPTH(8), .MAX_CYCLES(MAX_B)) dut_b (
        .core_clk(clk), .rst(rst), .ahb(bus_b), .char_valid(b_valid), .char_data(b_data),
        .char_ready(ready_b), .status(b_status), .done(b_done), .cycle_cnt(b_cnt), .drop_cnt(b_drop));

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model of dut_a: status 0..4, character queue, counters
    int unsigned  m_state = 0;
    byte unsigned m_q[$];
    int unsigned  m_drop  = 0;
    logic [31:0]  m_cnt   = '0;
    bit           m_pend  = 1'b0;
    bit           chk_model = 1'b0;

    typedef struct {
        logic [7:0] b;
        logic [2:0] st;
        bit         vld;
        logic [7:0] data;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit           have_b;
        byte unsigned b;
        logic [31:0]  cnt_before;
        if (rst) begin
            m_state = 0; m_q.delete(); m_drop = 0; m_cnt = '0; m_pend = 1'b0;
            return;
        end
        have_b = m_pend && (bus_a.hready === 1'b1) && (m_state <= 1);
        b      = bus_a.hwdata[7:0];
        if (bus_a.hready === 1'b1)
            m_pend = (bus_a.htrans[1] === 1'b1) && (bus_a.hwrite === 1'b1) && (bus_a.haddr === ADDR_A);
        if ((m_q.size() > 0) && ready_a) void'(m_q.pop_front());
        if (have_b && (b > 8'h06) && (b < 8'h7F)) begin
            if (m_q.size() < DEPTH_A) m_q.push_back(b);
            else if (m_drop != 32'hFFFF) m_drop++;
        end
        cnt_before = m_cnt;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            m_cnt = m_cnt + 32'd1;
            if (have_b && (b == 8'hFF)) m_state = 2;
            else if (have_b && (b == 8'h01)) m_state = 3;
            else if (WDOG && (cnt_before == MAX_A)) m_state = 4;
        end
    endtask

    task automatic model_compare();
        chk("m_status", 32'(a_status), m_state);
        chk("m_done", 32'(a_done), 32'(m_state >= 2));
        chk("m_valid", 32'(a_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk("m_data", 32'(a_data), 32'(m_q[0]));
        chk("m_cnt", a_cnt, m_cnt);
        chk("m_drop", 32'(a_drop), m_drop);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        if (chk_model) model_compare();
    endtask

    task automatic idle_buses();
        bus_a.haddr = '0; bus_a.htrans = 2'b00; bus_a.hwrite = 1'b0; bus_a.hwdata = '0; bus_a.hready = 1'b1;
        bus_b.haddr = '0; bus_b.htrans = 2'b00; bus_b.hwrite = 1'b0; bus_b.hwdata = '0; bus_b.hready = 1'b1;
    endtask

    task automatic addr_a(input bit on);
        bus_a.haddr  = on ? ADDR_A : 32'h0;
        bus_a.htrans = on ? 2'b10 : 2'b00;
        bus_a.hwrite = on;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_buses();
        step();
        rst = 1'b0;
        step();
    endtask

    // Back-to-back writes: address of byte i overlaps data of byte i-1
    task automatic wr_burst_a(input byte unsigned bs[$]);
        int n = bs.size();
        for (int i = 0; i <= n; i++) begin
            addr_a(i < n);
            bus_a.hwdata = (i > 0) ? 64'(bs[i-1]) : 64'h0;
            step();
        end
        idle_buses();
    endtask

    initial begin
        byte unsigned exp_q[$];
        vt[0] = '{8'h48, 3'd1, 1'b1, 8'h48};
        vt[1] = '{8'h06, 3'd1, 1'b0, 8'h00};
        vt[2] = '{8'h07, 3'd1, 1'b1, 8'h07};
        vt[3] = '{8'h7E, 3'd1, 1'b1, 8'h7E};
        vt[4] = '{8'h7F, 3'd1, 1'b0, 8'h00};
        vt[5] = '{8'h00, 3'd1, 1'b0, 8'h00};
        vt[6] = '{8'hFF, 3'd2, 1'b0, 8'h00};
        vt[7] = '{8'h01, 3'd3, 1'b0, 8'h00};
        vt[8] = '{8'h80, 3'd1, 1'b0, 8'h00};
        ready_a = 1'b1;
        ready_b = 1'b1;

        // Reset values
        rst = 1'b1;
        idle_buses();
        step();
        chk("rst_status", 32'(a_status), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_data", 32'(a_data), 32'd0);
        chk("rst_cnt", a_cnt, 32'd0);
        chk("rst_drop", 32'(a_drop), 32'd0);
        chk_model = 1'b1;
        rst = 1'b0;
        step();
        chk("idle_to_run", 32'(a_status), 32'd1);

        // Single-byte classification table
        for (int i = 0; i < 9; i++) begin
            do_reset();
            ready_a = 1'b1;
            wr_burst_a('{vt[i].b});
            chk($sformatf("tbl%0d_status", i), 32'(a_status), 32'(vt[i].st));
            chk($sformatf("tbl%0d_done", i), 32'(a_done), 32'(vt[i].st >= 3'd2));
            chk($sformatf("tbl%0d_valid", i), 32'(a_valid), 32'(vt[i].vld));
            if (vt[i].vld) chk($sformatf("tbl%0d_data", i), 32'(a_data), 32'(vt[i].data));
        end

        // Byte lane selection on a 32-bit bus
        do_reset();
        bus_b.haddr = 32'hD058_0000; bus_b.htrans = 2'b10; bus_b.hwrite = 1'b1;
        step();
        bus_b.htrans = 2'b00; bus_b.hwrite = 1'b0; bus_b.hwdata = 32'h0041_0000;
        step();
        idle_buses();
        chk("lane_valid", 32'(b_valid), 32'd1);
        chk("lane_data", 32'(b_data), 32'h41);

        // Full FIFO: drops, then simultaneous push/pop, then ordered drain
        do_reset();
        ready_a = 1'b0;
        wr_burst_a('{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66});
        chk("full_drop", 32'(a_drop), 32'd2);
        chk("full_head", 32'(a_data), 32'h61);
        addr_a(1'b1);
        step();
        addr_a(1'b0);
        bus_a.hwdata = 64'h67;
        ready_a = 1'b1;
        step();
        idle_buses();
        chk("pushpop_drop", 32'(a_drop), 32'd2);
        exp_q = '{8'h62, 8'h63, 8'h64, 8'h67};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(a_valid), 32'd1);
            chk($sformatf("drain%0d_data", i), 32'(a_data), 32'(exp_q[i]));
            step();
        end
        chk("drain_empty", 32'(a_valid), 32'd0);

        // PASS freezes the counter and ignores later writes
        do_reset();
        wr_burst_a('{8'hFF});
        chk("pass_status", 32'(a_status), 32'd2);
        chk("pass_done", 32'(a_done), 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk("pass_cnt_frozen", a_cnt, 32'd2);
        wr_burst_a('{8'h41});
        chk("pass_ignore_valid", 32'(a_valid), 32'd0);
        chk("pass_ignore_status", 32'(a_status), 32'd2);

        // Watchdog on dut_b (limit 16)
        do_reset();
        for (int i = 0; i < 16; i++) step();
        chk("wdog_pre_status", 32'(b_status), 32'd1);
        chk("wdog_pre_cnt", b_cnt, 32'd16);
        step();
        chk("wdog_status", 32'(b_status), WDOG ? 32'd4 : 32'd1);
        chk("wdog_done", 32'(b_done), WDOG ? 32'd1 : 32'd0);
        step();
        chk("wdog_cnt", b_cnt, WDOG ? 32'd17 : 32'd18);

        // Reset with queued characters and a pending data phase
        do_reset();
        ready_a = 1'b0;
        addr_a(1'b1);
        step();
        bus_a.hwdata = 64'h78;
        step();
        bus_a.hwdata = 64'h79;
        step();
        addr_a(1'b0);
        bus_a.hwdata = 64'h7A;
        rst = 1'b1;
        step();
        chk("midrst_valid", 32'(a_valid), 32'd0);
        chk("midrst_status", 32'(a_status), 32'd0);
        chk("midrst_drop", 32'(a_drop), 32'd0);
        rst = 1'b0;
        bus_a.hwdata = 64'h71;
        step();
        chk("midrst_no_pending", 32'(a_valid), 32'd0);
        idle_buses();

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            int unsigned r;
            rst = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 3);
            bus_a.haddr  = (r != 0) ? ADDR_A : ADDR_A + 32'($urandom_range(1, 12));
            bus_a.htrans = 2'($urandom_range(0, 3));
            bus_a.hwrite = ($urandom_range(0, 4) != 0);
            bus_a.hready = ($urandom_range(0, 6) != 0);
            bus_a.hwdata = {$urandom, $urandom};
            r = $urandom_range(0, 199);
            if (r < 150)      bus_a.hwdata[7:0] = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 198) bus_a.hwdata[7:0] = 8'($urandom_range(8'h02, 8'hFE));
            else              bus_a.hwdata[7:0] = (r == 198) ? 8'hFF : 8'h01;
            ready_a = ($urandom_range(0, 4) < 2);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
